// File: rtl/heater_control_mc.sv
// Multi-channel heater controller: settle blanking, one-shot heat, hysteresis hold,
// thermal-runaway and sensor open/short protection with a latched per-channel fault.
module heater_control_mc #(
  parameter int unsigned CHANNELS   = 2,
  parameter int unsigned ADC_W      = 12,
  parameter int unsigned SETTLE_CYC = 100,
  parameter int unsigned RUN_CYCLES = 2000000,
  parameter int unsigned RUN_DELTA  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [2*CHANNELS-1:0]     mode,
  input  logic [ADC_W*CHANNELS-1:0] adc,
  input  logic [ADC_W*CHANNELS-1:0] adc_upper,
  input  logic [ADC_W*CHANNELS-1:0] adc_lower,
  output logic [CHANNELS-1:0]       heater_en,
  output logic [CHANNELS-1:0]       done,
  output logic [CHANNELS-1:0]       fault,
  output logic                      fault_any
);

  localparam int unsigned TMR_W   = $clog2(RUN_CYCLES);
  localparam int unsigned CNT_RAW = $clog2(SETTLE_CYC + 1);
  localparam int unsigned CNT_W   = (CNT_RAW < 1) ? 1 : CNT_RAW;

  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(RUN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE_CYC);
  localparam logic [ADC_W:0]   DELTA    = (ADC_W + 1)'(RUN_DELTA);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_HEAT,
    S_DONE,
    S_HOLD_ON,
    S_HOLD_OFF,
    S_FAULT
  } state_e;

  state_e               state_q   [CHANNELS];
  state_e               state_d   [CHANNELS];
  logic [CNT_W-1:0]     cnt_q     [CHANNELS];
  logic [CNT_W-1:0]     cnt_d     [CHANNELS];
  logic [TMR_W-1:0]     tmr_q     [CHANNELS];
  logic [TMR_W-1:0]     tmr_d     [CHANNELS];
  logic [ADC_W-1:0]     ref_q     [CHANNELS];
  logic [ADC_W-1:0]     ref_d     [CHANNELS];
  logic [CHANNELS-1:0]  reached_q, reached_d;
  logic [CHANNELS-1:0]  heater_q,  heater_d;
  logic [CHANNELS-1:0]  fault_q,   fault_d;
  logic [2*CHANNELS-1:0] mode_q;

  always_comb begin
    logic [ADC_W-1:0] a;
    logic [ADC_W-1:0] up;
    logic [ADC_W-1:0] lo;
    logic [1:0]       m;
    logic [1:0]       mq;
    logic             sensor_bad;
    logic             progress;
    logic             active;

    reached_d = reached_q;
    heater_d  = '0;
    fault_d   = '0;

    for (int unsigned i = 0; i < CHANNELS; i++) begin
      a          = adc[i*ADC_W +: ADC_W];
      up         = adc_upper[i*ADC_W +: ADC_W];
      lo         = adc_lower[i*ADC_W +: ADC_W];
      m          = mode[2*i +: 2];
      mq         = mode_q[2*i +: 2];
      sensor_bad = (a == '0) || (a == '1);
      progress   = (({1'b0, a} + DELTA) <= {1'b0, ref_q[i]});
      active     = (state_q[i] == S_HEAT) || (state_q[i] == S_DONE) ||
                   (state_q[i] == S_HOLD_ON) || (state_q[i] == S_HOLD_OFF);

      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      tmr_d[i]   = tmr_q[i];
      ref_d[i]   = ref_q[i];

      if (state_q[i] == S_FAULT) begin
        // Latched: only an OFF command releases the channel, other changes are ignored.
        if (m == 2'b00 || m == 2'b11) begin
          state_d[i] = S_IDLE;
        end
      end else if (active && sensor_bad) begin
        state_d[i]   = S_FAULT;
        reached_d[i] = 1'b0;
      end else if (m != mq) begin
        state_d[i]   = S_SETTLE;
        cnt_d[i]     = CNT_INIT;
        reached_d[i] = 1'b0;
      end else begin
        unique case (state_q[i])
          S_SETTLE: begin
            if (cnt_q[i] != '0) begin
              cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end else if (m == 2'b01) begin
              state_d[i] = S_HEAT;
              ref_d[i]   = a;
              tmr_d[i]   = '0;
            end else if (m == 2'b10) begin
              if (a > up) begin
                state_d[i] = S_HOLD_ON;
                ref_d[i]   = a;
                tmr_d[i]   = '0;
              end else begin
                state_d[i]   = S_HOLD_OFF;
                reached_d[i] = 1'b1;
              end
            end else begin
              state_d[i] = S_IDLE;
            end
          end
          S_HEAT, S_HOLD_ON: begin
            // Runaway outranks the threshold: a timed-out window faults even at target.
            if (progress) begin
              ref_d[i] = a;
              tmr_d[i] = '0;
            end else if (tmr_q[i] == TMR_LAST) begin
              state_d[i]   = S_FAULT;
              reached_d[i] = 1'b0;
            end else begin
              tmr_d[i] = tmr_q[i] + TMR_W'(1);
            end
            if (state_d[i] != S_FAULT && a <= up) begin
              state_d[i]   = (state_q[i] == S_HEAT) ? S_DONE : S_HOLD_OFF;
              reached_d[i] = 1'b1;
            end
          end
          S_HOLD_OFF: begin
            if (a >= lo && a > up) begin
              state_d[i] = S_HOLD_ON;
              ref_d[i]   = a;
              tmr_d[i]   = '0;
            end
          end
          default: ;
        endcase
      end

      heater_d[i] = (state_d[i] == S_HEAT) || (state_d[i] == S_HOLD_ON);
      fault_d[i]  = (state_d[i] == S_FAULT);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        state_q[i] <= S_IDLE;
        cnt_q[i]   <= '0;
        tmr_q[i]   <= '0;
        ref_q[i]   <= '0;
      end
      reached_q <= '0;
      heater_q  <= '0;
      fault_q   <= '0;
      mode_q    <= '0;
    end else begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        tmr_q[i]   <= tmr_d[i];
        ref_q[i]   <= ref_d[i];
      end
      reached_q <= reached_d;
      heater_q  <= heater_d;
      fault_q   <= fault_d;
      mode_q    <= mode;
    end
  end

  assign heater_en = heater_q;
  assign done      = reached_q;
  assign fault     = fault_q;
  assign fault_any = |fault_q;

endmodule

// File: tb/tb_heater_control_mc.sv
// Directed bench for heater_control_mc: heat-once, hold hysteresis, runaway window,
// sensor-fault priority, settle restart and synchronous reset.
module tb_heater_control_mc;

  localparam int unsigned AW = 12;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  mode;
  logic [23:0] adc;
  logic [23:0] adc_upper;
  logic [23:0] adc_lower;
  logic [1:0]  heater_en;
  logic [1:0]  done;
  logic [1:0]  fault;
  logic        fault_any;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  heater_control_mc #(
    .CHANNELS  (2),
    .ADC_W     (12),
    .SETTLE_CYC(4),
    .RUN_CYCLES(16),
    .RUN_DELTA (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .mode     (mode),
    .adc      (adc),
    .adc_upper(adc_upper),
    .adc_lower(adc_lower),
    .heater_en(heater_en),
    .done     (done),
    .fault    (fault),
    .fault_any(fault_any)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tickn(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_ch(input int ch, input logic [1:0] m, input logic [11:0] a,
                        input logic [11:0] up, input logic [11:0] lo);
    mode[ch*2 +: 2]       = m;
    adc[ch*AW +: AW]       = a;
    adc_upper[ch*AW +: AW] = up;
    adc_lower[ch*AW +: AW] = lo;
  endtask

  task automatic set_adc(input int ch, input logic [11:0] a);
    adc[ch*AW +: AW] = a;
  endtask

  task automatic set_mode(input int ch, input logic [1:0] m);
    mode[ch*2 +: 2] = m;
  endtask

  initial begin
    set_ch(0, 2'b00, 12'd2000, 12'd1000, 12'd1050);
    set_ch(1, 2'b00, 12'd2000, 12'd1000, 12'd1050);
    rst = 1'b1;
    tickn(2);
    check("rst_heater", 32'(heater_en), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_fault", 32'(fault), 32'h0);
    check("rst_fault_any", 32'(fault_any), 32'h0);
    rst = 1'b0;
    tick();

    // HEAT_ONCE on ch0, adc ramps down 10 per edge from edge k
    set_ch(0, 2'b01, 12'd3000, 12'd1000, 12'd1050);
    tick();
    check("heat_blank_k", 32'(heater_en), 32'h0);
    for (int j = 1; j <= 4; j++) begin
      set_adc(0, 12'(3000 - 10 * j));
      tick();
    end
    check("heat_blank_k4", 32'(heater_en), 32'h0);
    set_adc(0, 12'd2950);
    tick();
    check("heat_on_k5", 32'(heater_en), 32'h1);
    check("heat_done_k5", 32'(done), 32'h0);
    for (int j = 6; j <= 199; j++) begin
      set_adc(0, 12'(3000 - 10 * j));
      tick();
    end
    check("heat_on_1010", 32'(heater_en), 32'h1);
    check("heat_done_1010", 32'(done), 32'h0);
    set_adc(0, 12'd1000);
    tick();
    check("heat_off_1000", 32'(heater_en), 32'h0);
    check("heat_done_1000", 32'(done), 32'h1);
    set_adc(0, 12'd1500);
    tickn(3);
    check("done_hold_heater", 32'(heater_en), 32'h0);
    check("done_hold_done", 32'(done), 32'h1);
    set_mode(0, 2'b00);
    tick();
    check("done_clr_on_mode", 32'(done), 32'h0);
    tickn(5);

    // HOLD hysteresis on ch1
    set_ch(1, 2'b10, 12'd1100, 12'd1000, 12'd1050);
    tickn(5);
    check("hold_blank_k4", 32'(heater_en), 32'h0);
    tick();
    check("hold_on_k5", 32'(heater_en), 32'h2);
    for (int v = 1090; v >= 1010; v -= 10) begin
      set_adc(1, 12'(v));
      tick();
    end
    check("hold_on_1010", 32'(heater_en), 32'h2);
    check("hold_done_1010", 32'(done), 32'h0);
    set_adc(1, 12'd1000);
    tick();
    check("hold_off_1000", 32'(heater_en), 32'h0);
    check("hold_done_1000", 32'(done), 32'h2);
    for (int v = 990; v <= 1040; v += 10) begin
      set_adc(1, 12'(v));
      tick();
    end
    check("hold_off_1040", 32'(heater_en), 32'h0);
    set_adc(1, 12'd1050);
    tick();
    check("hold_on_1050", 32'(heater_en), 32'h2);
    check("hold_done_1050", 32'(done), 32'h2);
    set_adc(1, 12'd1060);
    tick();
    check("hold_on_1060", 32'(heater_en), 32'h2);
    check("hold_done_1060", 32'(done), 32'h2);
    set_mode(1, 2'b00);
    tickn(6);

    // Runaway: drop of 7 does not re-arm the window
    set_ch(0, 2'b01, 12'd2000, 12'd1000, 12'd1050);
    tickn(6);
    check("run_entry_heater", 32'(heater_en), 32'h1);
    tickn(5);
    set_adc(0, 12'd1993);
    tickn(10);
    check("run7_e15_fault", 32'(fault), 32'h0);
    tick();
    check("run7_e16_fault", 32'(fault), 32'h1);
    check("run7_e16_any", 32'(fault_any), 32'h1);
    check("run7_e16_heater", 32'(heater_en), 32'h0);
    check("run7_e16_done", 32'(done), 32'h0);
    set_mode(0, 2'b10);
    tickn(7);
    check("fault_keeps_hold", 32'(fault), 32'h1);
    set_mode(0, 2'b00);
    tick();
    check("fault_clr_off", 32'(fault), 32'h0);
    check("fault_clr_any", 32'(fault_any), 32'h0);

    // Runaway: drop of 8 re-arms the window
    set_ch(0, 2'b01, 12'd2000, 12'd1000, 12'd1050);
    tickn(6);
    tickn(5);
    set_adc(0, 12'd1992);
    tickn(11);
    check("run8_e16_fault", 32'(fault), 32'h0);
    tickn(5);
    check("run8_e21_fault", 32'(fault), 32'h0);
    tick();
    check("run8_e22_fault", 32'(fault), 32'h1);
    set_mode(0, 2'b00);
    tick();
    check("run8_clr", 32'(fault), 32'h0);

    // Sensor fault outranks a simultaneous mode change; ch1 unaffected
    set_ch(0, 2'b10, 12'd900, 12'd1000, 12'd1050);
    set_ch(1, 2'b10, 12'd900, 12'd1000, 12'd1050);
    tickn(6);
    check("sens_holdoff_done", 32'(done), 32'h3);
    check("sens_holdoff_heater", 32'(heater_en), 32'h0);
    set_ch(0, 2'b01, 12'd4095, 12'd1000, 12'd1050);
    tick();
    check("sens_fault", 32'(fault), 32'h1);
    check("sens_done", 32'(done), 32'h2);
    check("sens_any", 32'(fault_any), 32'h1);

    // Settle restart on ch0 while ch1 latches a short fault, then reset
    set_ch(0, 2'b00, 12'd3000, 12'd1000, 12'd1050);
    tick();
    check("sens_clr", 32'(fault), 32'h0);
    set_mode(0, 2'b10);
    set_adc(1, 12'd0);
    tick();
    tickn(2);
    set_mode(0, 2'b01);
    tick();
    tickn(2);
    check("restart_k5_heater", 32'(heater_en), 32'h0);
    tickn(2);
    check("restart_k7_heater", 32'(heater_en), 32'h0);
    tick();
    check("restart_k8_heater", 32'(heater_en), 32'h1);
    check("restart_k8_fault", 32'(fault), 32'h2);
    check("restart_k8_any", 32'(fault_any), 32'h1);
    rst = 1'b1;
    tick();
    check("rst2_heater", 32'(heater_en), 32'h0);
    check("rst2_done", 32'(done), 32'h0);
    check("rst2_fault", 32'(fault), 32'h0);
    check("rst2_any", 32'(fault_any), 32'h0);
    rst = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/heater_control_mc.md
# heater_control_mc

Multi-channel, parametrised heater controller for the printer's hotend and bed thermistor channels. Per channel it runs a blanking/settle timer, a one-shot heat mode, a hysteresis hold mode, and thermal-runaway and sensor-open/short protection with a latched fault. It sits between the per-channel ADC filters and temperature-to-ADC-code converters on one side and the heater MOSFET drivers on the other.

## Interface
- CHANNELS, 2: number of independent heater channels (≥1)
- ADC_W, 12: ADC code width
- SETTLE_CYC, 100: blanking length after a mode change (≥0)
- RUN_CYCLES, 2000000: runaway window, in cycles of continuous heating without progress (≥2)
- RUN_DELTA, 8: minimum ADC-code drop that counts as progress (≥1)

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- mode  in  2*CHANNELS  per-channel command: 00 OFF, 01 HEAT_ONCE, 10 HOLD, 11 treated as OFF
- adc  in  ADC_W*CHANNELS  filtered thermistor code; code falls as temperature rises
- adc_upper  in  ADC_W*CHANNELS  target code (heater off at or below)
- adc_lower  in  ADC_W*CHANNELS  hysteresis re-enable code (heater on at or above)
- heater_en  out  CHANNELS  heater drive
- done  out  CHANNELS  target reached since the last mode change
- fault  out  CHANNELS  latched channel fault
- fault_any  out  1  OR of fault

## Operation
- Channels are fully independent; channel i uses slice i of every vector.
- States: IDLE, SETTLE, HEAT, DONE, HOLD_ON, HOLD_OFF, FAULT. heater_en=1 only in HEAT and HOLD_ON.
- mode_q is a registered copy of mode, updated every edge. A mode change means mode ≠ mode_q.
- Per-edge priority: rst > sensor fault > mode change > runaway > threshold.
- Sensor fault: adc==0 or adc==all-ones while in HEAT, DONE, HOLD_ON or HOLD_OFF → FAULT.
- Mode change (in any state except FAULT) → SETTLE with cnt=SETTLE_CYC and reached=0. A mode change during SETTLE restarts the count.
- SETTLE behaviour per edge:
  - cnt≠0: cnt--.
  - cnt==0, mode OFF → IDLE.
  - cnt==0, HEAT_ONCE → HEAT.
  - cnt==0, HOLD → HOLD_ON if adc>adc_upper, else HOLD_OFF with reached=1.
- HEAT: adc≤adc_upper → DONE with reached=1. DONE holds until the next mode change.
- HOLD_ON: adc≤adc_upper → HOLD_OFF with reached=1.
- HOLD_OFF: adc≥adc_lower and adc>adc_upper → HOLD_ON. The off condition wins if adc_lower≤adc_upper.
- done = reached.
- Runaway check, applied in HEAT and HOLD_ON:
  - On entry: ref=adc, tmr=0.
  - Each later edge: if adc+RUN_DELTA ≤ ref (computed at ADC_W+1 bits), then ref=adc and tmr=0.
  - Else if tmr==RUN_CYCLES-1 → FAULT.
  - Else tmr++.
  - Every entry to HOLD_ON re-arms the check.
- FAULT: heater_en=0, fault=1, done=0. The only exit is sampling mode==OFF → IDLE, which clears fault. All other mode changes are ignored.

## Timing
- Reset values: every channel in IDLE; heater_en=0, done=0, fault=0, fault_any=0; mode_q=00, cnt=0, tmr=0, ref=0.
- All outputs are registered and decoded from the next state. An input sampled at edge k shows on the outputs right after edge k (1-cycle latency).
- A mode change sampled at edge k gives heater_en=0 from k. The earliest heater_en=1 is at edge k+SETTLE_CYC+1.
- With a constant adc, runaway fault asserts at edge e+RUN_CYCLES, where e is the entry edge.
- fault_any follows fault in the same cycle: an OR of registers, with no extra register.
- tmr width is clog2(RUN_CYCLES). cnt width is clog2(SETTLE_CYC+1), with a minimum of 1 bit.

## Test plan
Config for all scenarios: CHANNELS=2, ADC_W=12, SETTLE_CYC=4, RUN_CYCLES=16, RUN_DELTA=8.
- **HEAT_ONCE:** ch0 mode=01 at edge k, adc=3000, upper=1000; adc ramps −10/cycle → heater_en[0]=1 at k+5; falls and done[0]=1 on the first edge with adc≤1000; heater stays 0 afterwards.
- **HOLD hysteresis:** ch1 mode=10, upper=1000, lower=1050; adc swept 1100→990→1060 → heater_en toggles 1→0 at 1000, 0→1 at 1050; done stays 1 after the first reach.
- **Runaway:** ch0 HEAT with adc frozen at 2000 → fault[0]=1 and fault_any=1 exactly 16 edges after HEAT entry; a drop of 7 does not reset the window, a drop of 8 does. mode=10 keeps the fault; mode=00 → fault=0, IDLE.
- **Sensor fault and priority:** adc=4095 during HOLD_OFF, with a mode change on the same edge → FAULT, not SETTLE; ch1 unaffected.
- **Restart and reset:** a mode change at SETTLE cnt=2 restarts the 5-cycle blank. rst asserted mid-HEAT with fault latched on ch1 → all outputs 0 on the next edge.
